add_sched: RTL and testbench
============================

ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter NREQ, default 4, sets the number of requesters; the requester index width is 2 at this default.
REQ-002 Parameter W, default 32, sets the width of the shared adder slice; the wide operand width is 2*W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept strobe, one-hot or zero.
REQ-007 req_wide  input  NREQ  1 = 2W-bit add, 0 = W-bit add.
REQ-008 req_a  input  NREQ*2W  operand A, requester i occupies bits [i*2W +: 2W].
REQ-009 req_b  input  NREQ*2W  operand B, packed the same way as req_a.
REQ-010 req_cin  input  NREQ  carry-in per requester.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_ready  input  1  consumer accepts the result.
REQ-013 resp_id  output  2  index of the requester that owns the result.
REQ-014 resp_sum  output  2W  sum; the upper W bits are zero for narrow operations.
REQ-015 resp_cout  output  1  carry-out of the final slice.

Function
REQ-016 The block SHALL share one W-bit adder among all requesters using an FSM with states IDLE, LO, HI and RESP.
REQ-017 In IDLE, if any req_valid bit is high, the block SHALL grant round-robin, searching from (last_grant+1) mod NREQ and wrapping 3->0.
REQ-018 In IDLE, the block SHALL assert req_ready of the granted requester for exactly that cycle, latch its operands, cin, wide flag and id, then go to LO.
REQ-019 In LO, the adder SHALL compute a[W-1:0]+b[W-1:0]+cin, and the block SHALL register the low sum and the carry.
REQ-020 From LO, a narrow operation SHALL go to RESP, and a wide operation SHALL go to HI.
REQ-021 In HI, the adder SHALL compute the upper halves plus the registered low carry, and the block SHALL register the high sum and the carry, then go to RESP.
REQ-022 In RESP, resp_valid SHALL be 1 with resp_sum, resp_cout and resp_id stable until the cycle in which resp_ready is 1.
REQ-023 In the cycle resp_ready=1 is seen in RESP, the block SHALL update last_grant to the served id and return to IDLE.
REQ-024 Latency from the accept edge SHALL be 2 cycles to resp_valid for narrow operations and 3 cycles for wide operations.
REQ-025 Peak throughput SHALL be one operation per 3 cycles for narrow and one per 4 cycles for wide, with resp_ready held high.
REQ-026 The block SHALL assert no req_ready bit outside IDLE; requests arriving in LO, HI or RESP SHALL wait.
REQ-027 Requesters MAY drop req_valid before being granted; the block SHALL sample req_valid only in IDLE.
REQ-028 A simultaneous request from all requesters SHALL be served in the order last_grant+1, +2, +3, +4 (mod 4).
REQ-029 Operand changes after the accept cycle SHALL NOT affect the result.
REQ-030 Sum arithmetic SHALL be modulo 2^(2W) for wide and 2^W for narrow operations, with the carry reported in resp_cout.

Reset
REQ-031 On rst_n=0, the block SHALL immediately enter IDLE, with req_ready=0, resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0 and last_grant=NREQ-1, so that requester 0 has first priority.
REQ-032 A reset during LO, HI or RESP SHALL discard the transaction without producing a response.

Structure
REQ-033 FSM state encodings and the NREQ/W defaults SHALL live in the shared package add_pkg.
REQ-034 The shared adder slice SHALL be one instance of the existing cla_32 carry-lookahead module; the arbiter SHALL be inline logic.
REQ-035 The design SHALL contain no other sub-modules.

Verification
REQ-036 Reset, then req_valid[2]=1, narrow, a=0xFFFFFFFF, b=1, cin=0 -> req_ready[2] pulses, and 2 cycles later resp_sum=0, resp_cout=1, resp_id=2.
REQ-037 Wide request on requester 1, a=0x00000000_FFFFFFFF, b=1, cin=0 -> resp_sum=0x00000001_00000000, resp_cout=0, after 3 cycles.
REQ-038 All four requesters held valid from reset -> grants in order 0,1,2,3,0; each resp_id matches its grant.
REQ-039 resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_sum and resp_id stay stable, and no req_ready is asserted.
REQ-040 rst_n pulled low during HI of a wide operation -> no response is produced, outputs are zero, and the next grant goes to requester 0.
REQ-041 Wide add a=b=0xFFFFFFFF_FFFFFFFF, cin=1 -> resp_sum=0xFFFFFFFF_FFFFFFFF, resp_cout=1.

Source files
------------

// File: rtl/add_pkg.sv
//------------------------------------------------------------------------------
// Module : add_pkg
// Brief  : Shared defaults and FSM state encoding for the add_sched block.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package add_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cla_32.sv
//------------------------------------------------------------------------------
// Module : cla_32
// Brief  : Carry-lookahead adder slice built from 4-bit lookahead groups.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cla_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = WIDTH / 4;

    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prop;
    logic [WIDTH:0]   w_carry;
    logic             w_grp_g;
    logic             w_grp_p;

    assign w_gen  = a & b;
    assign w_prop = a ^ b;

    // Group generate/propagate give each block's carry-out directly from its carry-in.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = cin;
        w_grp_g    = 1'b0;
        w_grp_p    = 1'b1;
        for (int blk = 0; blk < NBLK; blk++) begin
            w_grp_g = 1'b0;
            w_grp_p = 1'b1;
            for (int j = 0; j < 4; j++) begin
                w_carry[blk*4+j+1] = w_gen[blk*4+j] | (w_prop[blk*4+j] & w_carry[blk*4+j]);
                w_grp_g = w_gen[blk*4+j] | (w_prop[blk*4+j] & w_grp_g);
                w_grp_p = w_grp_p & w_prop[blk*4+j];
            end
            w_carry[blk*4+4] = w_grp_g | (w_grp_p & w_carry[blk*4]);
        end
    end

    assign sum  = w_prop ^ w_carry[WIDTH-1:0];
    assign cout = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/add_sched.sv
//------------------------------------------------------------------------------
// Module : add_sched
// Brief  : Round-robin scheduler sharing one W-bit adder across NREQ requesters.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module add_sched
    import add_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int W    = W_DEF,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_wide,
    input  logic [NREQ*2*W-1:0]   req_a,
    input  logic [NREQ*2*W-1:0]   req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [2*W-1:0]        resp_sum,
    output logic                  resp_cout
);

    state_t          r_state;
    logic [IDW-1:0]  r_last_grant;
    logic [IDW-1:0]  r_id;
    logic [2*W-1:0]  r_a;
    logic [2*W-1:0]  r_b;
    logic            r_cin;
    logic            r_wide;
    logic            r_carry;
    logic [W-1:0]    r_sum_lo;

    logic            w_found;
    logic [IDW-1:0]  w_grant_id;
    int              w_idx;
    logic [W-1:0]    w_add_a;
    logic [W-1:0]    w_add_b;
    logic            w_add_cin;
    logic [W-1:0]    w_add_sum;
    logic            w_add_cout;

    // Search starts one past the last served requester and wraps around.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = IDW'(w_idx);
            end
        end
    end

    // Accept strobe is only meaningful in the cycle the grant is taken.
    always_comb begin
        req_ready = '0;
        if (r_state == ST_IDLE && w_found) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        if (r_state == ST_HI) begin
            w_add_a   = r_a[2*W-1:W];
            w_add_b   = r_b[2*W-1:W];
            w_add_cin = r_carry;
        end else begin
            w_add_a   = r_a[W-1:0];
            w_add_b   = r_b[W-1:0];
            w_add_cin = r_cin;
        end
    end

    cla_32 #(
        .WIDTH (W)
    ) u_cla (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (w_add_cin),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_cin        <= 1'b0;
            r_wide       <= 1'b0;
            r_carry      <= 1'b0;
            r_sum_lo     <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_sum     <= '0;
            resp_cout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_a     <= req_a[w_grant_id*2*W +: 2*W];
                        r_b     <= req_b[w_grant_id*2*W +: 2*W];
                        r_cin   <= req_cin[w_grant_id];
                        r_wide  <= req_wide[w_grant_id];
                        r_id    <= w_grant_id;
                        r_state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (r_wide) begin
                        r_sum_lo <= w_add_sum;
                        r_carry  <= w_add_cout;
                        r_state  <= ST_HI;
                    end else begin
                        resp_sum   <= {{W{1'b0}}, w_add_sum};
                        resp_cout  <= w_add_cout;
                        resp_id    <= r_id;
                        resp_valid <= 1'b1;
                        r_state    <= ST_RESP;
                    end
                end
                ST_HI: begin
                    resp_sum   <= {w_add_sum, r_sum_lo};
                    resp_cout  <= w_add_cout;
                    resp_id    <= r_id;
                    resp_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid   <= 1'b0;
                        r_last_grant <= resp_id;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_add_sched.sv
//------------------------------------------------------------------------------
// Module : tb_add_sched
// Brief  : Directed vector bench for add_sched with multi-cycle corner sequences.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_add_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_wide;
    logic [NREQ*2*W-1:0]  req_a;
    logic [NREQ*2*W-1:0]  req_b;
    logic [NREQ-1:0]      req_cin;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [1:0]           resp_id;
    logic [2*W-1:0]       resp_sum;
    logic                 resp_cout;

    int tests = 0;
    int fails = 0;

    add_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wide   (req_wide),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          id;
        logic        wide;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic wide, input logic [63:0] a,
                          input logic [63:0] b, input logic cin);
        req_wide[id]      = wide;
        req_a[id*64 +: 64] = a;
        req_b[id*64 +: 64] = b;
        req_cin[id]       = cin;
    endtask

    task automatic wait_grant(input string name, input int id);
        int n;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check({name, "_grant"}, req_ready, 128'(4'b0001 << id));
    endtask

    task automatic run_vec(input vec_t v);
        resp_ready = 1'b1;
        set_op(v.id, v.wide, v.a, v.b, v.cin);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        #1;
        wait_grant(v.name, v.id);
        tick();
        // Operands scrambled right after acceptance must not leak into the result.
        req_valid = '0;
        set_op(v.id, ~v.wide, {$urandom, $urandom}, {$urandom, $urandom}, ~v.cin);
        check({v.name, "_lat1"}, resp_valid, 0);
        if (v.wide) begin
            tick();
            check({v.name, "_lat2"}, resp_valid, 0);
        end
        tick();
        check({v.name, "_valid"}, resp_valid, 1);
        check({v.name, "_sum"}, resp_sum, v.sum);
        check({v.name, "_cout"}, resp_cout, v.cout);
        check({v.name, "_id"}, resp_id, v.id);
        tick();
        check({v.name, "_done"}, resp_valid, 0);
    endtask

    initial begin
        int   exp_grant[5];
        int   pending[$];
        int   n_g;
        int   n_r;
        int   gidx;
        int   n;
        int   seen_valid;
        logic [63:0] held_sum;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_wide   = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = 1'b0;
        repeat (3) tick();

        check("rst_ready", req_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_sum", resp_sum, 0);
        check("rst_cout", resp_cout, 0);
        check("rst_id", resp_id, 0);
        rst_n = 1'b1;
        tick();

        vecs[0] = '{2, 1'b0, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1, "narrow_wrap"};
        vecs[1] = '{1, 1'b1, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0, "wide_lo_carry"};
        vecs[2] = '{0, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b1, "wide_all_ones"};
        vecs[3] = '{3, 1'b0, 64'h12345678, 64'h11111111, 1'b1, 64'h2345678A, 1'b0, "narrow_cin"};
        vecs[4] = '{0, 1'b0, 64'hDEADBEEF_00000005, 64'hFFFF0000_00000003, 1'b0, 64'h8, 1'b0, "narrow_upper_ignored"};
        vecs[5] = '{1, 1'b1, 64'h80000000_00000000, 64'h80000000_00000000, 1'b0, 64'h0, 1'b1, "wide_hi_carry"};
        vecs[6] = '{2, 1'b1, 64'h00000001_00000002, 64'h00000003_00000004, 1'b1, 64'h00000004_00000007, 1'b0, "wide_plain"};
        vecs[7] = '{3, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 64'h80000000_00000000, 1'b0, "wide_ripple"};

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // All four requesters held valid from reset: expect 0,1,2,3,0.
        rst_n = 1'b0;
        tick();
        exp_grant = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 1'b0, 64'(i * 100 + 5), 64'd7, 1'b0);
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        rst_n      = 1'b1;
        #1;
        n_g = 0;
        n_r = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (req_ready != '0) begin
                gidx = 0;
                for (int b = 0; b < NREQ; b++) if (req_ready[b]) gidx = b;
                check("rr_onehot", $countones(req_ready), 1);
                if (n_g < 5) check("rr_grant_order", gidx, exp_grant[n_g]);
                pending.push_back(gidx);
                n_g++;
            end
            if (resp_valid) begin
                if (pending.size() > 0) begin
                    gidx = pending.pop_front();
                    check("rr_resp_id", resp_id, gidx);
                    check("rr_resp_sum", resp_sum, 64'(gidx * 100 + 12));
                end else begin
                    check("rr_resp_without_grant", 1, 0);
                end
                n_r++;
            end
            if (n_r == 5) break;
            tick();
        end
        req_valid = '0;
        check("rr_resp_count", n_r, 5);
        tick();
        tick();

        // Response held off for 5 cycles while requester 3 waits.
        resp_ready = 1'b0;
        set_op(1, 1'b0, 64'hCAFE0000, 64'h0000BABE, 1'b0);
        req_valid = 4'b0010;
        #1;
        wait_grant("hold", 1);
        tick();
        req_valid = 4'b1000;
        set_op(3, 1'b0, 64'h1, 64'h2, 1'b0);
        n = 0;
        while (!resp_valid && n < 10) begin
            tick();
            n++;
        end
        check("hold_valid", resp_valid, 1);
        held_sum = 64'hCAFEBABE;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold_valid_stable", resp_valid, 1);
            check("hold_sum_stable", resp_sum, held_sum);
            check("hold_id_stable", resp_id, 1);
            check("hold_no_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        check("hold_release", resp_valid, 0);
        check("hold_next_grant", req_ready, 4'b1000);
        req_valid = '0;
        #1;
        check("drop_before_grant", req_ready, 0);
        tick();

        // Reset while a wide operation sits in HI.
        set_op(2, 1'b1, 64'h11111111_FFFFFFFF, 64'h1, 1'b0);
        req_valid = 4'b0100;
        #1;
        wait_grant("rst_hi", 2);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_hi_valid", resp_valid, 0);
        check("rst_hi_sum", resp_sum, 0);
        check("rst_hi_cout", resp_cout, 0);
        check("rst_hi_id", resp_id, 0);
        check("rst_hi_ready", req_ready, 0);
        tick();
        rst_n = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (resp_valid) seen_valid++;
        end
        check("rst_hi_no_resp", seen_valid, 0);
        req_valid = '1;
        #1;
        check("rst_hi_first_grant", req_ready, 4'b0001);
        req_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
